e203_exu_longp_src: RTL

- Producer side of the long-pipe writeback channel consumed by the EXU writeback arbiter.
- Tracks outstanding long-latency instructions (LSU loads, MulDiv) in an in-order tag FIFO. Each dispatched instruction gets a tag.
- Unit results come back out of order. They are released onto longp_wbck_o strictly in dispatch order.
- Also provides RAW/WAW hazard matches to dispatch.

---
 rtl/e203_exu_longp_src_pkg.sv | 25 ++
 rtl/e203_exu_longp_src_oitf.sv | 98 +++++++++
 rtl/e203_exu_longp_src.sv | 128 ++++++++++++
 3 files changed

// File: rtl/e203_exu_longp_src_pkg.sv
// Shared types and helpers for the long-pipe writeback source.
// Holds the default sizing constants, the outstanding-instruction entry
// layout and the wrap-bit pointer increment used by the OITF.
package e203_exu_longp_src_pkg;

    localparam int LONGP_DEPTH   = 4;
    localparam int LONGP_ITAG_W  = 2;
    localparam int LONGP_RFIDX_W = 5;
    localparam int LONGP_XLEN    = 32;
    localparam int LONGP_FLAG_W  = 5;

    typedef struct packed {
        logic                     vld;
        logic [LONGP_RFIDX_W-1:0] rdidx;
        logic                     rdfpu;
        logic                     rdwen;
    } oitf_ent_t;

    // Pointer is {wrap, index}. With a power-of-two depth a plain increment
    // modulo 2*DEPTH wraps the index and toggles the wrap bit together.
    function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int itag_w);
        ptr_inc = (p + 32'd1) & ((32'd2 << itag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/e203_exu_longp_src_oitf.sv
// Outstanding instruction tracking FIFO.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   alc_req, alc_*        allocation request and destination info
//   ret_ena               retire the head entry (caller guarantees !empty)
//   chk_*                 operand indices to compare against live entries
//   alc_idx, ret_idx      allocation / head tag
//   full, empty           occupancy from registered pointers
//   head_*                destination info of the head entry
//   match_*               hazard matches against vld & rdwen entries
module e203_exu_longp_oitf
    import e203_exu_longp_src_pkg::*;
#(
    parameter int DEPTH  = LONGP_DEPTH,
    parameter int ITAG_W = LONGP_ITAG_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alc_req,
    input  logic [LONGP_RFIDX_W-1:0] alc_rdidx,
    input  logic                     alc_rdfpu,
    input  logic                     alc_rdwen,
    input  logic                     ret_ena,
    input  logic [LONGP_RFIDX_W-1:0] chk_rs1idx,
    input  logic [LONGP_RFIDX_W-1:0] chk_rs2idx,
    input  logic [LONGP_RFIDX_W-1:0] chk_rdidx,
    input  logic                     chk_rs1fpu,
    input  logic                     chk_rs2fpu,
    input  logic                     chk_rdfpu,
    output logic [ITAG_W-1:0]        alc_idx,
    output logic [ITAG_W-1:0]        ret_idx,
    output logic                     full,
    output logic                     empty,
    output logic [LONGP_RFIDX_W-1:0] head_rdidx,
    output logic                     head_rdfpu,
    output logic                     head_rdwen,
    output logic                     match_rs1,
    output logic                     match_rs2,
    output logic                     match_rd
);

    oitf_ent_t [DEPTH-1:0] ents;
    logic [ITAG_W:0]       alc_ptr;
    logic [ITAG_W:0]       ret_ptr;
    logic                  alc_ena;
    logic [DEPTH-1:0]      hit_rs1;
    logic [DEPTH-1:0]      hit_rs2;
    logic [DEPTH-1:0]      hit_rd;

    assign alc_idx = alc_ptr[ITAG_W-1:0];
    assign ret_idx = ret_ptr[ITAG_W-1:0];
    assign empty   = (alc_ptr == ret_ptr);
    assign full    = (alc_idx == ret_idx) & (alc_ptr[ITAG_W] != ret_ptr[ITAG_W]);
    // Fullness is judged on registered state only; a same-cycle retire
    // does not open a slot.
    assign alc_ena = alc_req & ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alc_ptr <= '0;
            ret_ptr <= '0;
        end else begin
            if (alc_ena) alc_ptr <= (ITAG_W+1)'(ptr_inc(32'(alc_ptr), ITAG_W));
            if (ret_ena) ret_ptr <= (ITAG_W+1)'(ptr_inc(32'(ret_ptr), ITAG_W));
        end
    end

    // Allocate and retire never hit the same slot: equal indices mean
    // either full (no allocate) or empty (no retire).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ents <= '0;
        end else begin
            if (alc_ena) ents[alc_idx] <= '{vld: 1'b1, rdidx: alc_rdidx,
                                            rdfpu: alc_rdfpu, rdwen: alc_rdwen};
            if (ret_ena) ents[ret_idx].vld <= 1'b0;
        end
    end

    assign head_rdidx = ents[ret_idx].rdidx;
    assign head_rdfpu = ents[ret_idx].rdfpu;
    assign head_rdwen = ents[ret_idx].rdwen;

    // Registered entries only, so an allocating entry does not match in its
    // own cycle while a retiring one still does.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        logic live;
        assign live       = ents[i].vld & ents[i].rdwen;
        assign hit_rs1[i] = live & (ents[i].rdidx == chk_rs1idx) & (ents[i].rdfpu == chk_rs1fpu);
        assign hit_rs2[i] = live & (ents[i].rdidx == chk_rs2idx) & (ents[i].rdfpu == chk_rs2fpu);
        assign hit_rd[i]  = live & (ents[i].rdidx == chk_rdidx)  & (ents[i].rdfpu == chk_rdfpu);
    end

    assign match_rs1 = |hit_rs1;
    assign match_rs2 = |hit_rs2;
    assign match_rd  = |hit_rd;

endmodule

// File: rtl/e203_exu_longp_src.sv
// Long-pipe writeback source: releases LSU/MulDiv results to the writeback
// arbiter strictly in dispatch order.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   disp_*                     allocation handshake, tag and destination
//   chk_*, oitf_match_*        RAW/WAW hazard check for dispatch
//   oitf_empty                 nothing outstanding
//   lsu_wbck_i_*, mdv_wbck_i_* unit results (tagged, out of order)
//   longp_wbck_o_*             in-order writeback request to the arbiter
module e203_exu_longp_src
    import e203_exu_longp_src_pkg::*;
#(
    parameter int DEPTH   = LONGP_DEPTH,
    parameter int ITAG_W  = LONGP_ITAG_W,
    parameter int XLEN    = LONGP_XLEN,
    parameter int RFIDX_W = LONGP_RFIDX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    disp_ena,
    output logic                    disp_ready,
    output logic [ITAG_W-1:0]       disp_itag,
    input  logic [RFIDX_W-1:0]      disp_rdidx,
    input  logic                    disp_rdfpu,
    input  logic                    disp_rdwen,
    input  logic [RFIDX_W-1:0]      chk_rs1idx,
    input  logic [RFIDX_W-1:0]      chk_rs2idx,
    input  logic [RFIDX_W-1:0]      chk_rdidx,
    input  logic                    chk_rs1fpu,
    input  logic                    chk_rs2fpu,
    input  logic                    chk_rdfpu,
    output logic                    oitf_match_rs1,
    output logic                    oitf_match_rs2,
    output logic                    oitf_match_rd,
    output logic                    oitf_empty,
    input  logic                    lsu_wbck_i_valid,
    output logic                    lsu_wbck_i_ready,
    input  logic [XLEN-1:0]         lsu_wbck_i_wdat,
    input  logic [ITAG_W-1:0]       lsu_wbck_i_itag,
    input  logic                    mdv_wbck_i_valid,
    output logic                    mdv_wbck_i_ready,
    input  logic [XLEN-1:0]         mdv_wbck_i_wdat,
    input  logic [ITAG_W-1:0]       mdv_wbck_i_itag,
    input  logic [LONGP_FLAG_W-1:0] mdv_wbck_i_flags,
    output logic                    longp_wbck_o_valid,
    input  logic                    longp_wbck_o_ready,
    output logic [XLEN-1:0]         longp_wbck_o_wdat,
    output logic [LONGP_FLAG_W-1:0] longp_wbck_o_flags,
    output logic [RFIDX_W-1:0]      longp_wbck_o_rdidx,
    output logic                    longp_wbck_o_rdfpu
);

    logic [ITAG_W-1:0]  alc_idx;
    logic [ITAG_W-1:0]  ret_idx;
    logic               full;
    logic               empty;
    logic [RFIDX_W-1:0] head_rdidx;
    logic               head_rdfpu;
    logic               head_rdwen;
    logic               lsu_hit;
    logic               mdv_hit;
    logic               lsu_sel;
    logic               mdv_sel;
    logic               sel_vld;
    logic               sel_rdy;
    logic               ret_ena;

    e203_exu_longp_oitf #(
        .DEPTH  (DEPTH),
        .ITAG_W (ITAG_W)
    ) u_oitf (
        .clk        (clk),
        .rst_n      (rst_n),
        .alc_req    (disp_ena),
        .alc_rdidx  (disp_rdidx),
        .alc_rdfpu  (disp_rdfpu),
        .alc_rdwen  (disp_rdwen),
        .ret_ena    (ret_ena),
        .chk_rs1idx (chk_rs1idx),
        .chk_rs2idx (chk_rs2idx),
        .chk_rdidx  (chk_rdidx),
        .chk_rs1fpu (chk_rs1fpu),
        .chk_rs2fpu (chk_rs2fpu),
        .chk_rdfpu  (chk_rdfpu),
        .alc_idx    (alc_idx),
        .ret_idx    (ret_idx),
        .full       (full),
        .empty      (empty),
        .head_rdidx (head_rdidx),
        .head_rdfpu (head_rdfpu),
        .head_rdwen (head_rdwen),
        .match_rs1  (oitf_match_rs1),
        .match_rs2  (oitf_match_rs2),
        .match_rd   (oitf_match_rd)
    );

    assign disp_ready = ~full;
    assign disp_itag  = alc_idx;
    assign oitf_empty = empty;

    // Only the unit carrying the head tag may proceed; LSU wins a tie.
    assign lsu_hit = lsu_wbck_i_valid & (lsu_wbck_i_itag == ret_idx) & ~empty;
    assign mdv_hit = mdv_wbck_i_valid & (mdv_wbck_i_itag == ret_idx) & ~empty;
    assign lsu_sel = lsu_hit;
    assign mdv_sel = mdv_hit & ~lsu_hit;
    assign sel_vld = lsu_sel | mdv_sel;

    // An instruction with no destination retires without bothering the arbiter.
    assign sel_rdy = head_rdwen ? longp_wbck_o_ready : 1'b1;
    assign ret_ena = sel_vld & sel_rdy;

    assign lsu_wbck_i_ready = lsu_sel & sel_rdy;
    assign mdv_wbck_i_ready = mdv_sel & sel_rdy;

    assign longp_wbck_o_valid = sel_vld & head_rdwen;
    assign longp_wbck_o_wdat  = lsu_sel ? lsu_wbck_i_wdat : mdv_wbck_i_wdat;
    assign longp_wbck_o_flags = lsu_sel ? '0 : mdv_wbck_i_flags;
    assign longp_wbck_o_rdidx = head_rdidx;
    assign longp_wbck_o_rdfpu = head_rdfpu;

`ifndef SYNTHESIS
    // Tags are unique among outstanding entries, so two units can never
    // legitimately both claim the head.
    a_dual_head: assert property (@(posedge clk) disable iff (!rst_n) !(lsu_hit && mdv_hit))
        else $error("lsu and mdv both returned head tag %0d", ret_idx);
`endif

endmodule
